poly_disp_scan: RTL



---
 rtl/poly_disp_scan.sv | 111 +++++++++++
 1 files changed

// File: rtl/poly_disp_scan.sv
// Poly-voice display packer: scans voice sources over a req/vld handshake into a
// shadow slot buffer, then commits the whole frame to pd_out in a single edge.
module poly_disp_scan #(
  parameter int VOICES      = 8,
  parameter int CHANNELS    = 2,
  parameter int SLOT_W      = 16,
  parameter int NOTE_BASE   = 36,
  parameter int HOLD_FRAMES = 2,
  localparam int SLOTS = VOICES * CHANNELS,
  localparam int PD_W  = SLOTS * SLOT_W,
  localparam int VI_W  = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    req,
  output logic [VI_W-1:0]         vidx,
  input  logic                    vld,
  input  logic [CHANNELS-1:0]     note_on_in,
  input  logic [7*CHANNELS-1:0]   note_in,
  output logic                    done,
  output logic [PD_W-1:0]         pd_out
);

  typedef enum logic [1:0] {IDLE, REQ, COMMIT} state_t;

  localparam logic signed [8:0] NOTE_BASE_S = 9'(NOTE_BASE);
  localparam logic [3:0]        HOLD_INIT   = 4'(HOLD_FRAMES);

  state_t              state, state_nxt;
  logic                last_vidx;
  logic [SLOT_W-1:0]   shadow    [SLOTS];
  logic [6:0]          last_note [SLOTS];
  logic [3:0]          hold_cnt  [SLOTS];

  // Notes under the base clamp to offset 0 and raise the below-base flag.
  function automatic logic [SLOT_W-1:0] encode_slot(input logic [6:0] note,
                                                    input logic       on,
                                                    input logic       held);
    logic signed [8:0] diff;
    logic [SLOT_W-1:0] slot;
    diff = $signed({2'b00, note}) - NOTE_BASE_S;
    slot = '0;
    if (diff < 0) slot[10] = 1'b1;
    else          slot[6:0] = diff[6:0];
    slot[9] = on;
    slot[8] = held;
    return slot;
  endfunction

  assign last_vidx = (vidx == VI_W'(VOICES - 1));

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    req       = (state == REQ);
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (vld && last_vidx) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= IDLE;
      vidx   <= '0;
      done   <= 1'b0;
      pd_out <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        shadow[s]    <= '0;
        last_note[s] <= '0;
        hold_cnt[s]  <= '0;
      end
    end else begin
      state <= state_nxt;
      done  <= (state == COMMIT);
      case (state)
        IDLE: if (start) vidx <= '0;
        REQ: if (vld) begin
          for (int v = 0; v < VOICES; v++) begin
            if (VI_W'(v) == vidx) begin
              for (int c = 0; c < CHANNELS; c++) begin
                if (note_on_in[c]) begin
                  last_note[v*CHANNELS+c] <= note_in[7*c +: 7];
                  hold_cnt[v*CHANNELS+c]  <= HOLD_INIT;
                  shadow[v*CHANNELS+c]    <= encode_slot(note_in[7*c +: 7], 1'b1, 1'b0);
                end else if (hold_cnt[v*CHANNELS+c] != 4'd0) begin
                  hold_cnt[v*CHANNELS+c]  <= hold_cnt[v*CHANNELS+c] - 4'd1;
                  shadow[v*CHANNELS+c]    <= encode_slot(last_note[v*CHANNELS+c], 1'b0, 1'b1);
                end else begin
                  shadow[v*CHANNELS+c]    <= '0;
                end
              end
            end
          end
          if (!last_vidx) vidx <= vidx + VI_W'(1);
        end
        // Whole frame lands at once so the display never sees a partial scan.
        COMMIT: begin
          for (int s = 0; s < SLOTS; s++) pd_out[s*SLOT_W +: SLOT_W] <= shadow[s];
          vidx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
